// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer for the 5-stage MIPS pipeline: load-use bubbles,
// beq/j flushes, data-memory freeze with a sticky timeout, and a stall counter.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_branch_taken,
  input  logic                  id_jump,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  exmem_hold,
  output logic                  mem_timeout_err,
  output logic [15:0]           stall_count,
  output logic [1:0]            dbg_state,
  output logic [CNT_W-1:0]      dbg_wait_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic             err_q;
  logic             freeze;
  logic             load_use;

  // Memory handshake: mem_req marks a valid access in MEM; the access completes
  // in the cycle where mem_req & mem_ready. Until then the back end is frozen.
  assign freeze = mem_req & ~mem_ready;

  assign load_use = ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_hold   = 1'b0;
    if (rst) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (state == ERR) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      exmem_hold  = 1'b1;
      idex_bubble = 1'b1;
    end else if (freeze) begin
      // Hazards seen during a freeze are dropped; held stages re-present them.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      exmem_hold = 1'b1;
      if (state == RUN) begin
        state_nxt    = MEM_WAIT;
        wait_cnt_nxt = CNT_W'(1);
      end else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
        state_nxt = ERR;
      end else begin
        wait_cnt_nxt = wait_cnt + CNT_W'(1);
      end
    end else begin
      state_nxt    = RUN;
      wait_cnt_nxt = '0;
      if (ex_branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (id_jump) begin
        ifid_flush = 1'b1;
      end else if (load_use) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      err_q       <= 1'b0;
      stall_count <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (state_nxt == ERR) err_q <= 1'b1;
      if (!pc_write && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
    end
  end

  assign mem_timeout_err = err_q;
  assign dbg_state       = state;
  assign dbg_wait_cnt    = wait_cnt;

endmodule
